// File: rtl/fetch_align.sv
// Instruction fetch-alignment stage: fetches words from the I-cache, queues
// halfwords and hands one RV32IC instruction per cycle to the decoder.
module fetch_align #(
    parameter logic [31:0] RESET_PC = 32'h00000060
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        ready,
    output logic        valid,
    output logic [31:0] ir,
    output logic [31:0] pc,
    output logic        is_compressed
);
    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
    localparam logic [31:0] RESET_FETCH = {RESET_PC[31:2], 2'b00};

    state_t           state, state_next;
    logic [3:0][15:0] hb, hb_next;
    logic [2:0]       hw_cnt, cnt_next, base;
    logic [31:0]      head_pc, fetch_addr, drop_addr;
    logic             skip_low;

    logic       head_c, avail, consume, append;
    logic [1:0] cons_n, app_n;

    assign head_c        = hb[0][1:0] != 2'b11;
    assign avail         = head_c ? (hw_cnt >= 3'd1) : (hw_cnt >= 3'd2);
    assign valid         = avail && !rst && !redirect;
    assign is_compressed = avail && !rst && head_c;
    assign ir            = (!avail || rst) ? 32'h0 : (head_c ? {16'h0, hb[0]} : {hb[1], hb[0]});
    assign pc            = rst ? RESET_PC : head_pc;
    assign imem_read     = !rst && (state != IDLE);
    // A dropped request must keep presenting the address it was issued with.
    assign imem_address  = rst ? RESET_FETCH : ((state == DROP) ? drop_addr : fetch_addr);

    assign consume  = valid && ready;
    assign cons_n   = !consume ? 2'd0 : (head_c ? 2'd1 : 2'd2);
    assign append   = (state == REQ) && imem_resp && !redirect;
    assign app_n    = !append ? 2'd0 : (skip_low ? 2'd1 : 2'd2);
    assign base     = hw_cnt - {1'b0, cons_n};
    assign cnt_next = base + {1'b0, app_n};

    // Shift out consumed halfwords, then drop new ones in behind the survivors.
    always_comb begin
        hb_next = hb;
        case (cons_n)
            2'd1:    hb_next = {16'h0, hb[3:1]};
            2'd2:    hb_next = {32'h0, hb[3:2]};
            default: ;
        endcase
        for (int i = 0; i < 4; i++) begin
            if (app_n != 2'd0 && 3'(i) == base)
                hb_next[i[1:0]] = skip_low ? imem_rdata[31:16] : imem_rdata[15:0];
            if (app_n == 2'd2 && 3'(i) == base + 3'd1)
                hb_next[i[1:0]] = imem_rdata[31:16];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (hw_cnt <= 3'd2) state_next = REQ;
            REQ:     if (imem_resp) state_next = (cnt_next <= 3'd2) ? REQ : IDLE;
            DROP:    if (imem_resp) state_next = REQ;
            default: state_next = IDLE;
        endcase
        // An in-flight read with no response yet must be absorbed before refetching.
        if (redirect)
            state_next = (state == IDLE || imem_resp) ? REQ : DROP;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= REQ;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hb         <= '0;
            hw_cnt     <= 3'd0;
            head_pc    <= RESET_PC;
            fetch_addr <= RESET_FETCH;
            drop_addr  <= RESET_FETCH;
            skip_low   <= RESET_PC[1];
        end else if (redirect) begin
            hw_cnt     <= 3'd0;
            head_pc    <= redirect_pc & ~32'd1;
            fetch_addr <= redirect_pc & ~32'd3;
            skip_low   <= redirect_pc[1];
            if (state == REQ) drop_addr <= fetch_addr;
        end else begin
            hb     <= hb_next;
            hw_cnt <= cnt_next;
            if (consume) head_pc <= head_pc + {29'd0, cons_n, 1'b0};
            if (append) begin
                fetch_addr <= fetch_addr + 32'd4;
                skip_low   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_align.sv
// Bench for fetch_align: latency-configurable cache model plus an
// instruction-stream reference model derived straight from memory contents.
module tb_fetch_align;
    localparam logic [31:0] RESET_PC = 32'h00000060;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_address, ir, pc;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_read, valid, is_compressed;
    logic        imem_resp = 1'b0;
    logic        redirect = 1'b0;
    logic        ready = 1'b0;

    fetch_align #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_address(imem_address), .imem_read(imem_read),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .ready(ready), .valid(valid), .ir(ir), .pc(pc),
        .is_compressed(is_compressed)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory image: explicit words where a test sets them, a hash elsewhere.
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (mem.exists(w)) return mem[w];
        return (w * 32'h9E3779B1) ^ (w >> 7) ^ 32'h5BD1E995;
    endfunction

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a);
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic [31:0] insn_at(input logic [31:0] a);
        logic [15:0] lo;
        lo = hw_at(a);
        if (lo[1:0] != 2'b11) return {16'h0, lo};
        return {hw_at(a + 32'd2), lo};
    endfunction

    // Cache model: latches a request at an edge, answers lat cycles later.
    int          lat = 1;
    bit          rand_lat = 1'b0;
    bit          busy = 1'b0;
    int          cnt = 0;
    logic [31:0] req_addr = 32'h0;

    initial begin
        logic        s_read, s_rst;
        logic [31:0] s_addr;
        forever begin
            @(negedge clk);
            s_read = imem_read;
            s_addr = imem_address;
            s_rst  = rst;
            if (!s_rst && busy) begin
                checkb("read_held", s_read, 1'b1);
                check("addr_held", s_addr, req_addr);
            end
            @(posedge clk);
            #1;
            if (s_rst || imem_resp) begin
                busy = 1'b0;
                imem_resp = 1'b0;
            end else if (busy) begin
                if (cnt > 0) cnt--;
            end else if (s_read) begin
                busy = 1'b1;
                req_addr = s_addr;
                cnt = (rand_lat ? int'($urandom_range(4, 1)) : lat) - 1;
            end
            if (busy && cnt == 0 && !imem_resp) begin
                imem_resp  = 1'b1;
                imem_rdata = mem_word(req_addr);
            end else if (!imem_resp) begin
                imem_rdata = $urandom;
            end
        end
    end

    // Reference: the next instruction the decoder must see is the one in
    // memory at model_pc; redirects and resets just move model_pc.
    logic [31:0] model_pc = RESET_PC;
    logic [31:0] got_pc[$];
    logic [31:0] got_ir[$];
    logic        got_c[$];
    int          gap = 0;
    int          max_gap = 0;
    int          n_cons = 0;

    initial begin
        logic [31:0] exp_ir;
        forever begin
            @(negedge clk);
            if (rst) begin
                checkb("rst_valid", valid, 1'b0);
                check("rst_ir", ir, 32'h0);
                checkb("rst_isc", is_compressed, 1'b0);
                checkb("rst_read", imem_read, 1'b0);
                check("rst_pc", pc, RESET_PC);
                check("rst_addr", imem_address, {RESET_PC[31:2], 2'b00});
                model_pc = RESET_PC;
                gap = 0;
            end else begin
                check("addr_align", {30'h0, imem_address[1:0]}, 32'h0);
                if (redirect) begin
                    checkb("valid_in_redirect", valid, 1'b0);
                    model_pc = redirect_pc & ~32'd1;
                    gap = 0;
                end else if (valid) begin
                    exp_ir = insn_at(model_pc);
                    check("pc", pc, model_pc);
                    check("ir", ir, exp_ir);
                    checkb("is_c", is_compressed, exp_ir[1:0] != 2'b11);
                    if (ready) begin
                        got_pc.push_back(pc);
                        got_ir.push_back(ir);
                        got_c.push_back(is_compressed);
                        n_cons++;
                        model_pc += (exp_ir[1:0] != 2'b11) ? 32'd2 : 32'd4;
                        gap = 0;
                    end
                end else begin
                    check("ir_idle", ir, 32'h0);
                    checkb("isc_idle", is_compressed, 1'b0);
                    if (ready) gap++;
                end
                if (gap > max_gap) max_gap = gap;
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        cyc(3);
        got_pc.delete();
        got_ir.delete();
        got_c.delete();
        rst = 1'b0;
    endtask

    task automatic wait_cons(input int n, input int limit);
        int k;
        k = 0;
        while (got_pc.size() < n && k < limit) begin
            cyc();
            k++;
        end
        checkb("wait_cons", got_pc.size() >= n, 1'b1);
    endtask

    task automatic fill_cnop(input logic [31:0] from, input logic [31:0] to);
        for (logic [31:0] a = from; a < to; a += 32'd4) mem[a] = 32'h00010001;
    endtask

    task automatic run_prog(input logic [31:0] w0, input logic [31:0] w1);
        mem.delete();
        mem[32'h60] = w0;
        mem[32'h64] = w1;
        lat = 1;
        rand_lat = 1'b0;
        ready = 1'b1;
        do_reset();
        wait_cons(3, 50);
    endtask

    initial begin
        int k, n0, n_rand;
        logic [31:0] hold_pc, hold_ir;

        // Two aligned 32-bit instructions
        run_prog(32'h00000513, 32'h00100593);
        check("t1_pc0", got_pc[0], 32'h60);
        check("t1_ir0", got_ir[0], 32'h00000513);
        checkb("t1_c0", got_c[0], 1'b0);
        check("t1_pc1", got_pc[1], 32'h64);
        check("t1_ir1", got_ir[1], 32'h00100593);
        checkb("t1_c1", got_c[1], 1'b0);

        // Two compressed in one word
        run_prog(32'h45054501, 32'h00010001);
        check("t2_pc0", got_pc[0], 32'h60);
        check("t2_ir0", got_ir[0], 32'h00004501);
        checkb("t2_c0", got_c[0], 1'b1);
        check("t2_pc1", got_pc[1], 32'h62);
        check("t2_ir1", got_ir[1], 32'h00004505);
        checkb("t2_c1", got_c[1], 1'b1);

        // 32-bit instruction straddling a word boundary
        run_prog(32'h05130001, 32'h00010000);
        check("t3_ir0", got_ir[0], 32'h00000001);
        check("t3_pc1", got_pc[1], 32'h62);
        check("t3_ir1", got_ir[1], 32'h00000513);
        check("t3_pc2", got_pc[2], 32'h66);
        check("t3_ir2", got_ir[2], 32'h00000001);

        // Compressed stream from a 1-cycle cache: one instruction per cycle
        mem.delete();
        fill_cnop(32'h60, 32'h100);
        lat = 1;
        ready = 1'b1;
        do_reset();
        k = 0;
        while (!valid && k < 20) begin cyc(); k++; end
        n0 = n_cons;
        cyc(16);
        check("throughput", 32'(n_cons - n0), 32'd16);

        // Decoder stall: buffer fills, fetch stops, outputs hold
        ready = 1'b0;
        do_reset();
        cyc(12);
        checkb("stall_read", imem_read, 1'b0);
        check("stall_pc", pc, 32'h60);
        check("stall_ir", ir, 32'h00000001);
        hold_pc = pc;
        hold_ir = ir;
        cyc(3);
        check("hold_pc", pc, hold_pc);
        check("hold_ir", ir, hold_ir);
        checkb("hold_valid", valid, 1'b1);
        ready = 1'b1;
        wait_cons(8, 60);
        for (int i = 0; i < 8; i++) check("release_order", got_pc[i], 32'h60 + 32'(2 * i));

        // Redirect while a slow read of 0x68 is outstanding
        mem.delete();
        fill_cnop(32'h60, 32'h80);
        mem[32'h68]  = 32'h45814581;
        mem[32'h100] = 32'h00014501;
        mem[32'h104] = 32'h00010001;
        lat = 5;
        ready = 1'b1;
        do_reset();
        k = 0;
        while (!(imem_read && imem_address == 32'h68) && k < 100) begin cyc(); k++; end
        check("drop_setup_addr", imem_address, 32'h68);
        redirect = 1'b1;
        redirect_pc = 32'h103;
        cyc();
        redirect = 1'b0;
        got_pc.delete();
        got_ir.delete();
        got_c.delete();
        checkb("drop_read", imem_read, 1'b1);
        check("drop_stale_addr", imem_address, 32'h68);
        k = 0;
        while (imem_address == 32'h68 && k < 20) begin cyc(); k++; end
        check("refetch_addr", imem_address, 32'h100);
        wait_cons(1, 40);
        check("redir_pc", got_pc[0], 32'h102);
        check("redir_ir", got_ir[0], 32'h00000001);

        // Redirect, response and ready in the same cycle
        mem.delete();
        fill_cnop(32'h60, 32'h100);
        lat = 1;
        ready = 1'b1;
        do_reset();
        cyc(4);
        k = 0;
        while (!imem_resp && k < 10) begin cyc(); k++; end
        checkb("coinc_resp", imem_resp, 1'b1);
        checkb("coinc_valid_pre", valid, 1'b1);
        redirect = 1'b1;
        redirect_pc = 32'h200;
        #1;
        checkb("coinc_valid", valid, 1'b0);
        cyc();
        redirect = 1'b0;
        checkb("coinc_read", imem_read, 1'b1);
        check("coinc_addr", imem_address, 32'h200);
        check("coinc_pc", pc, 32'h200);

        // Randomised run: random latency, stalls, redirects and one reset
        mem.delete();
        rand_lat = 1'b1;
        do_reset();
        n0 = n_cons;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            ready = ($urandom % 4) != 0;
            redirect = ($urandom % 25) == 0;
            redirect_pc = 32'h1000 | ($urandom & 32'h3FF);
            cyc();
        end
        redirect = 1'b0;
        n_rand = n_cons - n0;
        checkb("rand_progress", n_rand >= 300, 1'b1);
        checkb("max_gap", max_gap <= 40, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
